// File: rtl/reorder_out_buff.sv
// reorder_out_buff_pkg: token types shared by the reorder buffer and its neighbours.
//   FTk_t : forward token {data, v (valid), r (release)}
//   BTk_t : backward token {n (nack)}
package reorder_out_buff_pkg;
  localparam int unsigned DATA_W = 8;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              v;
    logic              r;
  } FTk_t;

  typedef struct packed {
    logic n;
  } BTk_t;
endpackage

// reorder_out_buff: tag-allocated reorder buffer with NUM_WR out-of-order
// write ports and in-order retirement onto a single forward-token output.
// Ports:
//   clock, reset   : clock, synchronous active-high reset
//   I_Active       : enable for retirement
//   I_Alloc        : allocate the head slot; O_AllocTag names it
//   O_Full/O_Empty/O_Count : occupancy, from the registered count
//   I_WrV/I_WrTag/I_WrFTk  : per-port result write (port 0 highest priority)
//   O_FTk          : retired token ('0 when nothing retires)
//   I_BTk/O_BTk    : backward tokens; O_BTk.n = nack | full
//   O_Err          : sticky illegal-write flag (cleared only by reset)
module reorder_out_buff
  import reorder_out_buff_pkg::*;
#(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned NUM_WR      = 2,
  parameter int unsigned TAG_W       = $clog2(DEPTH),
  parameter int unsigned RETIME_NACK = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          I_Active,
  input  logic                          I_Alloc,
  output logic [TAG_W-1:0]              O_AllocTag,
  output logic                          O_Full,
  output logic                          O_Empty,
  output logic [TAG_W:0]                O_Count,
  input  logic [NUM_WR-1:0]             I_WrV,
  input  logic [NUM_WR-1:0][TAG_W-1:0]  I_WrTag,
  input  FTk_t [NUM_WR-1:0]             I_WrFTk,
  output FTk_t                          O_FTk,
  input  BTk_t                          I_BTk,
  output BTk_t                          O_BTk,
  output logic                          O_Err
);

  localparam logic [TAG_W:0] DEPTH_CNT = (TAG_W+1)'(DEPTH);

  logic [TAG_W-1:0]  head, tail;
  logic [TAG_W:0]    count;
  logic [DEPTH-1:0]  alloc_q, valid_q;
  FTk_t              mem [DEPTH];
  logic              err_q, nack_q, nack;
  logic              full, do_alloc, en_out, release_tok;
  logic [NUM_WR-1:0] shadow, wr_en;
  logic              wr_err;
  FTk_t              entry;

  assign nack     = (RETIME_NACK != 0) ? nack_q : I_BTk.n;
  assign full     = (count == DEPTH_CNT);
  assign do_alloc = I_Alloc & ~full;
  assign entry    = mem[tail];

  // Reset gates retirement so nothing is emitted during the reset cycle.
  assign en_out      = ~reset & I_Active & ~nack & valid_q[tail] & alloc_q[tail];
  assign release_tok = en_out & entry.r;

  // Port arbitration: a port is shadowed when a lower-index port targets the
  // same tag; shadowed, unallocated or already-valid writes are dropped.
  always_comb begin
    shadow = '0;
    wr_en  = '0;
    wr_err = 1'b0;
    for (int unsigned k = 1; k < NUM_WR; k++) begin
      for (int unsigned j = 0; j < k; j++) begin
        if (I_WrV[j] && I_WrV[k] && (I_WrTag[j] == I_WrTag[k]))
          shadow[k] = 1'b1;
      end
    end
    for (int unsigned k = 0; k < NUM_WR; k++) begin
      if (I_WrV[k]) begin
        if (shadow[k] || !alloc_q[I_WrTag[k]] || valid_q[I_WrTag[k]])
          wr_err = 1'b1;
        else
          wr_en[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      alloc_q <= '0;
      valid_q <= '0;
      err_q   <= 1'b0;
      nack_q  <= 1'b0;
    end else begin
      nack_q <= I_BTk.n;
      if (wr_err)
        err_q <= 1'b1;
      if (release_tok) begin
        // Release flushes everything, including a same-cycle allocation.
        head    <= '0;
        tail    <= '0;
        count   <= '0;
        alloc_q <= '0;
        valid_q <= '0;
      end else begin
        if (do_alloc) begin
          alloc_q[head] <= 1'b1;
          valid_q[head] <= 1'b0;
          head          <= head + 1'b1;
        end
        for (int unsigned k = 0; k < NUM_WR; k++) begin
          if (wr_en[k])
            valid_q[I_WrTag[k]] <= 1'b1;
        end
        if (en_out) begin
          alloc_q[tail] <= 1'b0;
          valid_q[tail] <= 1'b0;
          tail          <= tail + 1'b1;
        end
        case ({do_alloc, en_out})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Payload storage needs no reset: Valid[] guards every read.
  always_ff @(posedge clock) begin
    for (int unsigned k = 0; k < NUM_WR; k++) begin
      if (wr_en[k])
        mem[I_WrTag[k]] <= I_WrFTk[k];
    end
  end

  always_comb begin
    O_FTk   = en_out ? entry : '0;
    O_BTk   = '0;
    O_BTk.n = nack | full;
  end

  assign O_AllocTag = head;
  assign O_Full     = full;
  assign O_Empty    = (count == '0);
  assign O_Count    = count;
  assign O_Err      = err_q;

endmodule

// File: doc/reorder_out_buff.md
Name: reorder_out_buff

Overview:
Parametrised successor to the index-compression output buffer. It is a tag-allocated reorder buffer with NUM_WR independent write ports (exec pipeline lanes, thru/skip path, …) and in-order retirement onto a single forward-token output. Slots are allocated at issue. Results arrive out of order by tag and retire in allocation order under backward-token (nack) control. The block sits between the exec/skip units and the downstream link of an index-compression element.

Parameters:
DEPTH, 8, number of buffer entries; power of two, ≥2.
NUM_WR, 2, number of write ports; port 0 has highest priority.
TAG_W, $clog2(DEPTH), tag/pointer width (derived).
RETIME_NACK, 1, 1 = register I_BTk.n one cycle before use; 0 = use it combinationally.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
I_Active  in  1  module enable; retirement occurs only when high
I_Alloc  in  1  allocate the head slot (fire into pipeline)
O_AllocTag  out  TAG_W  tag for this cycle's allocation (= head pointer)
O_Full  out  1  all DEPTH slots allocated
O_Empty  out  1  no slot allocated
O_Count  out  TAG_W+1  number of allocated slots
I_WrV  in  NUM_WR  per-port write valid
I_WrTag  in  NUM_WR×TAG_W  per-port target tag
I_WrFTk  in  NUM_WR×FTk_t  per-port forward token (data, v, r)
O_FTk  out  FTk_t  retired forward token
I_BTk  in  BTk_t  backward token from downstream
O_BTk  out  BTk_t  backward token upstream
O_Err  out  1  sticky: write to an unallocated or already-valid slot

Behaviour:
- Reset: all pointers, Alloc[], Valid[], count and O_Err cleared. Outputs: O_FTk='0, O_AllocTag=0, O_Full=0, O_Empty=1, O_Count=0, O_BTk='0.
- Nack = RETIME_NACK ? registered I_BTk.n : I_BTk.n. The retimed register resets to 0.
- Allocation:
  - When I_Alloc & ~O_Full: set Alloc[head], clear Valid[head], and increment head (mod DEPTH) next cycle.
  - O_AllocTag equals head combinationally.
  - Alloc while O_Full is ignored; no state change.
  - O_Full derives from the registered count only. A retire in the same cycle does not unblock an alloc.
- Write:
  - Port k with I_WrV[k] & Alloc[tag] & ~Valid[tag] stores I_WrFTk[k] and sets Valid[tag] next cycle.
  - If two ports target the same tag in one cycle, the lowest index wins and O_Err sets.
  - A write to an unallocated or already-valid tag is dropped and O_Err sets.
- Retire:
  - EnOut = Valid[tail] & Alloc[tail] & ~Nack & I_Active.
  - When EnOut, O_FTk = entry[tail] (combinational, zero-latency from valid state). Otherwise O_FTk = '0.
  - On retire: clear Alloc[tail] and Valid[tail], tail++ (mod DEPTH), count--.
- Count: alloc and retire in the same cycle leave count unchanged. Pointers wrap silently; full/empty are distinguished by count.
- Write-to-retire latency: minimum 1 cycle (write at cycle t, entry visible at t+1).
- Release token: if the retired entry has r=1, then next cycle head, tail, count, Alloc[] and Valid[] clear, i.e. the buffer empties regardless of pending slots. An alloc in the same cycle is discarded. O_Err is unaffected.
- Backpressure: O_BTk.n = Nack | O_Full. Other O_BTk fields are zero.
- Nack mid-stream: O_FTk is '0 and no state advances; held entries retire in order once Nack drops.
- Reset mid-operation: all in-flight entries are lost and no outputs are emitted in the reset cycle.

Test Plan:
- In-order fill: DEPTH=8. Alloc tags 0..3, write tags 0..3 in order on port 0 (data 0xA0..0xA3) -> O_FTk emits 0xA0..0xA3 on consecutive cycles; O_Empty=1 afterwards.
- Out-of-order: alloc 0..3; write tag3, tag1, tag0, tag2 (port1, port0 alternating) -> retire order 0,1,2,3. No output until tag0 is written; then 0,1 retire, stall, then 2,3.
- Full/wrap: alloc 8 slots -> O_Full=1, O_BTk.n=1, a 9th alloc is ignored (O_AllocTag holds 0). Retire 2, alloc 2 -> tags 0,1 reused; count=8.
- Nack: RETIME_NACK=1, tail valid, I_BTk.n=1 for 3 cycles -> output stops one cycle after nack rises and resumes one cycle after it falls, with no loss or duplication.
- Release: alloc 0..2; write tag1 with r=1, tag0 normal -> tag0 then tag1 retire. Next cycle count=0, head=tail=0, and tag2's later write sets O_Err.
- Conflict: ports 0 and 1 write tag 5 in the same cycle -> port-0 data is stored and O_Err=1 persists until reset.
